// File: rtl/game_pkg.sv
// Shared game-logic definitions: scheduler states, VGA 640x480@60 timing,
// and the default number of per-frame update engines.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int N_TASK_DEF = 4;

endpackage

// File: rtl/line_edge_det.sv
// Registers the line counter and pulses when the scan first lands on LINE.
module line_edge_det
    import game_pkg::*;
#(
    parameter int LINE = 0,
    parameter int W    = 10
) (
    input  logic         clk_50MHz,
    input  logic         rst_n,
    input  logic [W-1:0] v_count,
    output logic         line_edge
);

    localparam logic [W-1:0] LINE_V = W'(LINE);

    logic [W-1:0] v_prev;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            v_prev <= '0;
        end else begin
            v_prev <= v_count;
        end
    end

    assign line_edge = (v_count == LINE_V) && (v_prev != LINE_V);

endmodule

// File: rtl/vblank_scheduler.sv
// Runs the enabled game-update engines one at a time during vertical blanking
// and flags an overrun if active video restarts before the sequence ends.
module vblank_scheduler
    import game_pkg::*;
#(
    parameter int N_TASK   = game_pkg::N_TASK_DEF,
    parameter int V_ACTIVE = game_pkg::V_ACTIVE,
    parameter int V_TOTAL  = game_pkg::V_TOTAL
) (
    input  logic              clk_50MHz,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [9:0]        v_count,
    input  logic [N_TASK-1:0] task_mask,
    output logic [N_TASK-1:0] task_start,
    input  logic [N_TASK-1:0] task_done,
    output logic [2:0]        active_idx,
    output logic              busy,
    output logic              frame_tick,
    output logic [15:0]       frame_cnt,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam logic [2:0] LAST    = 3'(N_TASK - 1);
    localparam logic [9:0] V_LIMIT = 10'(V_TOTAL);

    sched_state_t state;
    sched_state_t state_nx;
    logic [2:0]   idx;
    logic [2:0]   idx_nx;
    logic         tick_nx;
    logic         ovr_set;

    logic         vb_edge;
    logic         av_edge;
    logic         in_range;
    logic         vb_go;
    logic         av_go;

    logic [7:0]   mask_w;
    logic [7:0]   done_w;
    logic [7:0]   start_w;

    line_edge_det #(
        .LINE (V_ACTIVE),
        .W    (10)
    ) u_vb_det (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .v_count   (v_count),
        .line_edge (vb_edge)
    );

    line_edge_det #(
        .LINE (0),
        .W    (10)
    ) u_av_det (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .v_count   (v_count),
        .line_edge (av_edge)
    );

    assign in_range = (v_count < V_LIMIT);
    assign vb_go    = vb_edge && in_range;
    assign av_go    = av_edge && in_range;

    assign mask_w = 8'(task_mask);
    assign done_w = 8'(task_done);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tick_nx  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (vb_go && enable) begin
                    state_nx = ST_SCAN;
                    idx_nx   = '0;
                    tick_nx  = 1'b1;
                end
            end
            ST_SCAN: begin
                if (mask_w[idx]) begin
                    state_nx = ST_START;
                end else if (idx == LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    idx_nx = idx + 3'd1;
                end
            end
            ST_START: begin
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_w[idx]) begin
                    if (idx == LAST) begin
                        state_nx = ST_IDLE;
                    end else begin
                        idx_nx   = idx + 3'd1;
                        state_nx = ST_SCAN;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // Active video restarting wins over any completion this cycle
        if ((state != ST_IDLE) && av_go) begin
            state_nx = ST_IDLE;
        end
    end

    assign ovr_set = (state != ST_IDLE) && av_go;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            frame_tick <= tick_nx;
            if (tick_nx) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign start_w    = (state == ST_START) ? (8'd1 << idx) : 8'd0;
    assign task_start = start_w[N_TASK-1:0];
    assign busy       = (state != ST_IDLE);
    assign active_idx = idx;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Scoreboard bench for vblank_scheduler: expected start pulses are queued
// when a frame is triggered and matched as the DUT issues them.
module tb_vblank_scheduler;

    localparam int N = 4;

    logic         clk_50MHz;
    logic         rst_n;
    logic         enable;
    logic [9:0]   v_count;
    logic [N-1:0] task_mask;
    logic [N-1:0] task_start;
    logic [N-1:0] task_done;
    logic [2:0]   active_idx;
    logic         busy;
    logic         frame_tick;
    logic [15:0]  frame_cnt;
    logic         overrun;
    logic         overrun_clr;

    logic [N-1:0] eng_done;
    logic [N-1:0] inj_done;

    typedef struct {
        int idx;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          start_cyc[N];
    int          hang_idx;
    int          cyc;
    int          ticks;
    int          t_line;
    int          n_checks;
    int          n_fail;
    logic [15:0] exp_frames;

    assign task_done = eng_done | inj_done;

    vblank_scheduler #(
        .N_TASK   (N),
        .V_ACTIVE (480),
        .V_TOTAL  (525)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .rst_n       (rst_n),
        .enable      (enable),
        .v_count     (v_count),
        .task_mask   (task_mask),
        .task_start  (task_start),
        .task_done   (task_done),
        .active_idx  (active_idx),
        .busy        (busy),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Engine model: completion pulse 3 cycles after its start
    always @(posedge clk_50MHz) begin
        #1;
        for (int i = 0; i < N; i++)
            eng_done[i] = (cyc == start_cyc[i] + 3) && (hang_idx != i);
    end

    always @(negedge clk_50MHz) begin
        exp_t e;
        if (rst_n && frame_tick === 1'b1) ticks++;
        if (task_start !== '0) begin
            for (int i = 0; i < N; i++)
                if (task_start[i] === 1'b1) start_cyc[i] = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_unexpected: task_start=%b at cycle %0d, required none",
                         task_start, cyc);
            end else begin
                e = exp_q.pop_front();
                if (task_start !== N'(1 << e.idx) || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL start_order: task_start=%b at cycle %0d, required %b at cycle %0d",
                             task_start, cyc, N'(1 << e.idx), e.cyc);
                end
            end
        end
    end

    function automatic void push_expected(int t, logic [N-1:0] mask, int hang);
        int cur = t + 1;
        int s;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                s = cur + 1;
                exp_q.push_back('{i, s});
                if (i == hang) return;
                cur = s + 4;
            end else begin
                cur = cur + 1;
            end
        end
    endfunction

    task automatic set_line(input logic [9:0] v);
        @(posedge clk_50MHz); #1;
        v_count = v;
        t_line  = cyc;
        @(posedge clk_50MHz); #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_50MHz); #1;
        end
        @(negedge clk_50MHz);
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            @(posedge clk_50MHz); #1;
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d starts still pending, required 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        logic [9:0] seq [4];
        seq = '{10'd470, 10'd479, 10'd480, 10'd481};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_50MHz); #1;
            v_count = seq[i];
            @(posedge clk_50MHz); #1;
            @(negedge clk_50MHz);
            n_checks++;
            if ({task_start, active_idx, busy, frame_tick, frame_cnt, overrun} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: start=%b idx=%0d busy=%b tick=%b cnt=%0d ovr=%b, required all 0",
                         task_start, active_idx, busy, frame_tick, frame_cnt, overrun);
            end
        end
        n_checks++;
        if (ticks != 0) begin
            n_fail++;
            $display("FAIL reset_tick: %0d ticks, required 0", ticks);
        end
        @(posedge clk_50MHz); #1;
        v_count = 10'd100;
        @(posedge clk_50MHz); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full;
        int t;
        int t0;
        task_mask = 4'b1111;
        hang_idx  = -1;
        t0 = ticks;
        set_line(10'd479);
        set_line(10'd480);
        t = t_line;
        push_expected(t, task_mask, -1);
        exp_frames++;
        @(negedge clk_50MHz);
        n_checks++;
        if (frame_tick !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_tick: tick=%b busy=%b, required 1 1", frame_tick, busy);
        end
        drain(60);
        wait_until(t + 20);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_busy_hold: busy=%b, required 1", busy);
        end
        wait_until(t + 21);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_busy_fall: busy=%b, required 0", busy);
        end
        n_checks++;
        if (frame_cnt !== exp_frames || ticks - t0 != 1) begin
            n_fail++;
            $display("FAIL full_count: cnt=%0d ticks=%0d, required %0d and 1",
                     frame_cnt, ticks - t0, exp_frames);
        end
    endtask

    task automatic test_skip;
        int t;
        task_mask = 4'b1010;
        set_line(10'd479);
        set_line(10'd480);
        t = t_line;
        push_expected(t, task_mask, -1);
        exp_frames++;
        while (cyc < t + 4) begin
            @(posedge clk_50MHz); #1;
        end
        inj_done = 4'b0001;
        @(posedge clk_50MHz); #1;
        inj_done = 4'b0000;
        drain(60);
        wait_until(t + 12);
        n_checks++;
        if (busy !== 1'b1 || active_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL skip_wait3: busy=%b idx=%0d, required 1 3", busy, active_idx);
        end
        wait_until(t + 13);
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL skip_end: busy=%b cnt=%0d, required 0 %0d",
                     busy, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_overrun;
        task_mask = 4'b1111;
        hang_idx  = 1;
        set_line(10'd479);
        set_line(10'd480);
        push_expected(t_line, task_mask, 1);
        exp_frames++;
        drain(60);
        set_line(10'd524);
        @(negedge clk_50MHz);
        n_checks++;
        if (busy !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_before: busy=%b ovr=%b, required 1 0", busy, overrun);
        end
        set_line(10'd0);
        @(negedge clk_50MHz);
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_abort: ovr=%b busy=%b, required 1 0", overrun, busy);
        end
        repeat (30) @(posedge clk_50MHz);
        #1;
        overrun_clr = 1'b1;
        @(posedge clk_50MHz); #1;
        overrun_clr = 1'b0;
        @(negedge clk_50MHz);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: ovr=%b, required 0", overrun);
        end
        task_mask = 4'b0001;
        hang_idx  = 0;
        set_line(10'd479);
        set_line(10'd480);
        push_expected(t_line, task_mask, 0);
        exp_frames++;
        drain(60);
        set_line(10'd524);
        @(posedge clk_50MHz); #1;
        v_count     = 10'd0;
        overrun_clr = 1'b1;
        @(posedge clk_50MHz); #1;
        overrun_clr = 1'b0;
        @(negedge clk_50MHz);
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_set_wins: ovr=%b busy=%b, required 1 0", overrun, busy);
        end
        @(posedge clk_50MHz); #1;
        overrun_clr = 1'b1;
        @(posedge clk_50MHz); #1;
        overrun_clr = 1'b0;
        hang_idx    = -1;
        n_checks++;
        if (frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL ovr_count: cnt=%0d, required %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_enable_wrap;
        int t;
        int t0;
        enable    = 1'b0;
        task_mask = 4'b0000;
        t0 = ticks;
        set_line(10'd479);
        set_line(10'd480);
        @(negedge clk_50MHz);
        n_checks++;
        if (frame_tick !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_ignored: tick=%b busy=%b, required 0 0", frame_tick, busy);
        end
        repeat (5) @(negedge clk_50MHz);
        n_checks++;
        if (frame_cnt !== exp_frames || ticks != t0) begin
            n_fail++;
            $display("FAIL en_count: cnt=%0d ticks=%0d, required %0d %0d",
                     frame_cnt, ticks, exp_frames, t0);
        end
        enable = 1'b1;
        @(posedge clk_50MHz); #1;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        @(negedge clk_50MHz);
        n_checks++;
        if (frame_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: cnt=%h, required ffff", frame_cnt);
        end
        exp_frames = 16'hFFFF + 16'd1;
        set_line(10'd479);
        set_line(10'd480);
        t = t_line;
        @(negedge clk_50MHz);
        n_checks++;
        if (frame_tick !== 1'b1 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL wrap_cnt: tick=%b cnt=%h, required 1 %h",
                     frame_tick, frame_cnt, exp_frames);
        end
        wait_until(t + 4);
        n_checks++;
        if (busy !== 1'b1 || active_idx !== 3'd3) begin
            n_fail++;
            $display("FAIL mask0_scan: busy=%b idx=%0d, required 1 3", busy, active_idx);
        end
        wait_until(t + 5);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mask0_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        task_mask = 4'b1111;
        hang_idx  = 2;
        set_line(10'd479);
        set_line(10'd480);
        push_expected(t_line, task_mask, 2);
        drain(60);
        repeat (4) @(negedge clk_50MHz);
        n_checks++;
        if (busy !== 1'b1 || active_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL rmid_wait: busy=%b idx=%0d, required 1 2", busy, active_idx);
        end
        @(posedge clk_50MHz); #1;
        rst_n   = 1'b0;
        v_count = 10'd100;
        #1;
        n_checks++;
        if (busy !== 1'b0 || active_idx !== 3'd0 || frame_cnt !== 16'd0 || task_start !== '0) begin
            n_fail++;
            $display("FAIL rmid_async: busy=%b idx=%0d cnt=%0d start=%b, required 0 0 0 0",
                     busy, active_idx, frame_cnt, task_start);
        end
        exp_q.delete();
        hang_idx   = -1;
        exp_frames = 16'd0;
        repeat (3) @(posedge clk_50MHz);
        #1;
        rst_n = 1'b1;
        set_line(10'd479);
        set_line(10'd480);
        t = t_line;
        push_expected(t, task_mask, -1);
        exp_frames++;
        drain(60);
        wait_until(t + 21);
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL rmid_restart: busy=%b cnt=%0d, required 0 %0d",
                     busy, frame_cnt, exp_frames);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        v_count     = 10'd0;
        task_mask   = 4'b1111;
        overrun_clr = 1'b0;
        inj_done    = 4'b0000;
        eng_done    = 4'b0000;
        hang_idx    = -1;
        cyc         = 0;
        ticks       = 0;
        t_line      = 0;
        n_checks    = 0;
        n_fail      = 0;
        exp_frames  = 16'd0;
        for (int i = 0; i < N; i++) start_cyc[i] = -100;

        test_reset;
        test_full;
        test_skip;
        test_overrun;
        test_enable_wrap;
        test_reset_mid;

        repeat (5) @(posedge clk_50MHz);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
